// File: rtl/tick_scheduler.sv
// Shared free-running counter with NUM_CH tick channels, each pulsing when its tapped counter bit rises.
// Optional macro TICK_SCHEDULER_ONESHOT_EN adds a per-channel one-shot mode (cfg_oneshot input).
module tick_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4
) (
  input  logic                          clk_src,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [$clog2(NUM_CH)-1:0]     cfg_ch,
  input  logic [$clog2(DATA_WIDTH)-1:0] cfg_tap,
  input  logic                          cfg_en,
`ifdef TICK_SCHEDULER_ONESHOT_EN
  input  logic                          cfg_oneshot,
`endif
  output logic [NUM_CH-1:0]             tick,
  output logic                          running,
  output logic [DATA_WIDTH-1:0]         count
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int TAP_W = $clog2(DATA_WIDTH);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                  state;
  logic [NUM_CH-1:0]       en;
  logic [TAP_W-1:0]        tap [NUM_CH];
  logic [NUM_CH-1:0]       tick_next;
  logic [DATA_WIDTH-1:0]   count_inc;
  logic                    stay_run;
  logic                    xfer;
`ifdef TICK_SCHEDULER_ONESHOT_EN
  logic [NUM_CH-1:0]       oneshot;
`endif

  // Config handshake: a transfer happens on any edge with cfg_valid && cfg_ready;
  // cfg_ready then drops for exactly one cycle and cfg_valid may stay high meanwhile.
  assign xfer      = cfg_valid & cfg_ready;
  assign stay_run  = (state == RUN) && !stop;
  assign count_inc = count + DATA_WIDTH'(1);

  // A tick fires on the 0->1 transition of the tapped bit; a transfer to the
  // same channel masks it so a tap change cannot produce a spurious pulse.
  always_comb begin
    tick_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      tick_next[i] = stay_run && en[i] && !count[tap[i]] && count_inc[tap[i]]
                     && !(xfer && (cfg_ch == CH_W'(i)));
    end
  end

  always_ff @(posedge clk_src) begin
    if (!rst_n) begin
      state     <= IDLE;
      running   <= 1'b0;
      count     <= '0;
      tick      <= '0;
      en        <= '0;
      cfg_ready <= 1'b1;
      for (int i = 0; i < NUM_CH; i++) tap[i] <= '0;
`ifdef TICK_SCHEDULER_ONESHOT_EN
      oneshot   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state   <= RUN;
            running <= 1'b1;
            count   <= '0;
          end
        end
        RUN: begin
          if (stop) begin
            state   <= IDLE;
            running <= 1'b0;
          end else begin
            count   <= count_inc;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase

      tick      <= tick_next;
      cfg_ready <= !xfer;

`ifdef TICK_SCHEDULER_ONESHOT_EN
      for (int i = 0; i < NUM_CH; i++) begin
        if (oneshot[i] && tick_next[i]) en[i] <= 1'b0;
      end
`endif
      if (xfer) begin
        en[cfg_ch]  <= cfg_en;
        tap[cfg_ch] <= cfg_tap;
`ifdef TICK_SCHEDULER_ONESHOT_EN
        oneshot[cfg_ch] <= cfg_oneshot;
`endif
      end
    end
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler: a default-width instance plus a 4-bit instance for wrap checks.
module tb_tick_scheduler;

  logic       clk_src = 1'b0;
  logic       rst_n, start, stop, cfg_valid, cfg_en, cfg_oneshot;
  logic [1:0] cfg_ch;
  logic [4:0] cfg_tap;
  logic       cfg_ready, running;
  logic [3:0] tick;
  logic [31:0] count;

  logic       rst4_n, start4, stop4, c4_valid, c4_en, c4_oneshot;
  logic       c4_ch;
  logic [1:0] c4_tap;
  logic       rdy4, run4;
  logic [1:0] t4;
  logic [3:0] cnt4;

  int checks   = 0;
  int failures = 0;
  bit m_en  [4];
  int m_tap [4];

  always #5 clk_src = ~clk_src;

  tick_scheduler #(.DATA_WIDTH(32), .NUM_CH(4)) u_dut (
    .clk_src(clk_src), .rst_n(rst_n), .start(start), .stop(stop),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_tap(cfg_tap), .cfg_en(cfg_en),
`ifdef TICK_SCHEDULER_ONESHOT_EN
    .cfg_oneshot(cfg_oneshot),
`endif
    .tick(tick), .running(running), .count(count)
  );

  tick_scheduler #(.DATA_WIDTH(4), .NUM_CH(2)) u_dut4 (
    .clk_src(clk_src), .rst_n(rst4_n), .start(start4), .stop(stop4),
    .cfg_valid(c4_valid), .cfg_ready(rdy4), .cfg_ch(c4_ch),
    .cfg_tap(c4_tap), .cfg_en(c4_en),
`ifdef TICK_SCHEDULER_ONESHOT_EN
    .cfg_oneshot(c4_oneshot),
`endif
    .tick(t4), .running(run4), .count(cnt4)
  );

  task automatic step();
    @(posedge clk_src);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Channel i pulses when the counter has just reached a value with
  // (c mod 2^(tap+1)) == 2^tap, i.e. its tapped bit just rose.
  function automatic logic [3:0] exp_ticks(input int c);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (m_en[i] && ((c % (1 << (m_tap[i] + 1))) == (1 << m_tap[i]))) r[i] = 1'b1;
    end
    return r;
  endfunction

  initial begin
    rst_n = 0; start = 0; stop = 0; cfg_valid = 0; cfg_en = 0; cfg_oneshot = 0;
    cfg_ch = '0; cfg_tap = '0;
    rst4_n = 0; start4 = 0; stop4 = 0; c4_valid = 0; c4_en = 0; c4_oneshot = 0;
    c4_ch = '0; c4_tap = '0;
    for (int i = 0; i < 4; i++) begin m_en[i] = 0; m_tap[i] = 0; end
    step(); step();

    chk("rst_running", 32'(running), 32'd0);
    chk("rst_count", count, 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    chk("rst4_ready", 32'(rdy4), 32'd1);

    // 4-bit counter: tap 3 ticks at 8, wraps 15->0, ticks at 8 again; reset at count 5
    rst4_n = 1;
    c4_valid = 1; c4_ch = 1'b0; c4_tap = 2'd3; c4_en = 1;
    step();
    chk("w4_ready_busy", 32'(rdy4), 32'd0);
    c4_valid = 0; start4 = 1;
    step();
    start4 = 0;
    chk("w4_running", 32'(run4), 32'd1);
    chk("w4_count0", 32'(cnt4), 32'd0);
    for (int k = 1; k <= 37; k++) begin
      step();
      chk("w4_count", 32'(cnt4), 32'(k % 16));
      chk("w4_tick", 32'(t4), 32'((k % 16) == 8));
    end
    rst4_n = 0;
    step();
    chk("w4_rst_count", 32'(cnt4), 32'd0);
    chk("w4_rst_running", 32'(run4), 32'd0);
    chk("w4_rst_tick", 32'(t4), 32'd0);
    chk("w4_rst_ready", 32'(rdy4), 32'd1);

    // ch0 tap0, start: ticks at odd counts
    rst_n = 1;
    cfg_valid = 1; cfg_ch = 2'd0; cfg_tap = 5'd0; cfg_en = 1;
    step();
    chk("b_ready_busy", 32'(cfg_ready), 32'd0);
    chk("b_idle", 32'(running), 32'd0);
    cfg_valid = 0; start = 1;
    step();
    start = 0;
    m_en[0] = 1; m_tap[0] = 0;
    chk("b_running", 32'(running), 32'd1);
    chk("b_count0", count, 32'd0);
    chk("b_tick0", 32'(tick), 32'd0);
    chk("b_ready_back", 32'(cfg_ready), 32'd1);
    for (int c = 1; c <= 8; c++) begin
      step();
      chk("b_count", count, 32'(c));
      chk("b_tick", 32'(tick), 32'(exp_ticks(c)));
    end

    // cfg_valid held 3 cycles: ready 1,0,1 -> ch1 then ch2 accepted
    cfg_valid = 1; cfg_ch = 2'd1; cfg_tap = 5'd2; cfg_en = 1;
    chk("c_ready_pre", 32'(cfg_ready), 32'd1);
    step();
    chk("c_ready_1", 32'(cfg_ready), 32'd0);
    cfg_ch = 2'd2; cfg_tap = 5'd3;
    step();
    chk("c_ready_2", 32'(cfg_ready), 32'd1);
    step();
    chk("c_ready_3", 32'(cfg_ready), 32'd0);
    cfg_valid = 0;
    m_en[1] = 1; m_tap[1] = 2; m_en[2] = 1; m_tap[2] = 3;
    chk("c_count11", count, 32'd11);
    for (int c = 12; c <= 32; c++) begin
      step();
      chk("c_count", count, 32'(c));
      chk("c_tick", 32'(tick), 32'(exp_ticks(c)));
    end

    // start+stop together in RUN: stop wins, count frozen
    start = 1; stop = 1;
    step();
    chk("d_running", 32'(running), 32'd0);
    chk("d_count_frozen", count, 32'd32);
    chk("d_tick", 32'(tick), 32'd0);
    step();
    chk("d_idle_both", 32'(running), 32'd0);
    start = 0; stop = 0;
    step();
    chk("d_count_hold", count, 32'd32);
    start = 1;
    step();
    start = 0;
    chk("d_restart_running", 32'(running), 32'd1);
    chk("d_restart_count", count, 32'd0);

    // retune ch0 tap0 -> tap3 at count 6: no tick at 7, tick at 8
    for (int c = 1; c <= 6; c++) begin
      step();
      chk("e_tick", 32'(tick), 32'(exp_ticks(c)));
    end
    cfg_valid = 1; cfg_ch = 2'd0; cfg_tap = 5'd3; cfg_en = 1;
    step();
    cfg_valid = 0;
    chk("e_count7", count, 32'd7);
    chk("e_no_tick7", 32'(tick), 32'd0);
    chk("e_ready_busy", 32'(cfg_ready), 32'd0);
    m_tap[0] = 3;
    for (int c = 8; c <= 16; c++) begin
      step();
      chk("e_tick", 32'(tick), 32'(exp_ticks(c)));
    end
    stop = 1;
    step();
    stop = 0;
    chk("e_stop_running", 32'(running), 32'd0);
    chk("e_stop_count", count, 32'd16);
    chk("e_stop_tick", 32'(tick), 32'd0);

`ifdef TICK_SCHEDULER_ONESHOT_EN
    // one-shot ch0 tap1: single pulse at count 2
    start = 1;
    step();
    start = 0;
    chk("f_count0", count, 32'd0);
    cfg_valid = 1; cfg_ch = 2'd0; cfg_tap = 5'd1; cfg_en = 1; cfg_oneshot = 1;
    step();
    cfg_valid = 0; cfg_oneshot = 0;
    chk("f_tick_c1", 32'(tick[0]), 32'd0);
    for (int c = 2; c <= 10; c++) begin
      step();
      chk("f_oneshot_tick", 32'(tick[0]), 32'(c == 2));
    end
    stop = 1;
    step();
    stop = 0;
`endif

    // reset mid-RUN with an offered transfer: offer dropped, config cleared
    start = 1;
    step();
    start = 0;
    step(); step();
    chk("g_count2", count, 32'd2);
    rst_n = 0; cfg_valid = 1; cfg_ch = 2'd1; cfg_tap = 5'd0; cfg_en = 1;
    step();
    chk("g_rst_running", 32'(running), 32'd0);
    chk("g_rst_count", count, 32'd0);
    chk("g_rst_tick", 32'(tick), 32'd0);
    chk("g_rst_ready", 32'(cfg_ready), 32'd1);
    rst_n = 1; cfg_valid = 0; start = 1;
    step();
    start = 0;
    for (int c = 1; c <= 4; c++) begin
      step();
      chk("g_count", count, 32'(c));
      chk("g_no_tick", 32'(tick), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
